// File: rtl/regfile_sb_pkg.sv
// Shared widths and types for the RV32I register file and its pending-write scoreboard.
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing signal bundle of regfile_sb; the register file is the slave side.
interface regfile_sb_if;
  import rf_pkg::*;

  logic      i_rd_wren;
  reg_addr_t i_rd_addr;
  reg_data_t i_rd_data;
  reg_addr_t i_rs1_addr;
  reg_addr_t i_rs2_addr;
  reg_data_t o_rs1_data;
  reg_data_t o_rs2_data;
  logic      i_issue_valid;
  reg_addr_t i_issue_rd;
  logic      i_retire;
  logic      i_flush;
  logic      o_rs1_busy;
  logic      o_rs2_busy;
  logic      o_sb_overflow;

  modport slave (
    input  i_rd_wren, i_rd_addr, i_rd_data, i_rs1_addr, i_rs2_addr,
    input  i_issue_valid, i_issue_rd, i_retire, i_flush,
    output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_sb_overflow
  );

  modport master (
    output i_rd_wren, i_rd_addr, i_rd_data, i_rs1_addr, i_rs2_addr,
    output i_issue_valid, i_issue_rd, i_retire, i_flush,
    input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_sb_overflow
  );
endinterface

// File: rtl/regfile_sb_counter.sv
// Saturating up/down pending-writer counter; clr beats inc/dec, inc+dec together holds.
module sb_counter
  import rf_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output cnt_t o_cnt,
  output logic o_ovf
);
  cnt_t cnt_q;
  cnt_t cnt_d;

  // next count and overflow pulse (an issue into a saturated counter)
  always_comb begin
    cnt_d = cnt_q;
    o_ovf = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !i_dec) begin
      if (cnt_q == CNT_MAX) begin
        o_ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (i_dec && !i_inc) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// RV32I register file with per-register pending-write scoreboard.
// Optional same-cycle forwarding (data and retire-aware busy) under REGFILE_BYPASS_EN.
module regfile_sb
  import rf_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  regfile_sb_if.slave  bus
);
  reg_data_t           regs_q [NUM_REGS];
  cnt_t                cnt_s  [NUM_REGS];
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0] ovf_s;
  logic                ovf_q;
  logic                ovf_d;
  reg_data_t           rs1_data_s;
  reg_data_t           rs2_data_s;
  logic                rs1_busy_s;
  logic                rs2_busy_s;

  assign cnt_s[0] = '0;
  assign inc_s[0] = 1'b0;
  assign dec_s[0] = 1'b0;
  assign ovf_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    assign inc_s[r] = bus.i_issue_valid && (bus.i_issue_rd == ADDR_W'(r));
    assign dec_s[r] = bus.i_retire && (bus.i_rd_addr == ADDR_W'(r));
    sb_counter u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (inc_s[r]),
      .i_dec   (dec_s[r]),
      .i_clr   (bus.i_flush),
      .o_cnt   (cnt_s[r]),
      .o_ovf   (ovf_s[r])
    );
  end

  assign ovf_d = ovf_q | (|ovf_s);

  // register array; x0 is never written so it stays zero after reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.i_rd_wren && (bus.i_rd_addr != '0)) begin
      regs_q[bus.i_rd_addr] <= bus.i_rd_data;
    end
  end

  // sticky overflow flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // source 1 read and busy
  always_comb begin
    rs1_data_s = (bus.i_rs1_addr == '0) ? '0 : regs_q[bus.i_rs1_addr];
    rs1_busy_s = (bus.i_rs1_addr != '0) && (cnt_s[bus.i_rs1_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    if (bus.i_rd_wren && (bus.i_rd_addr == bus.i_rs1_addr) && (bus.i_rs1_addr != '0)) begin
      rs1_data_s = bus.i_rd_data;
    end else begin
      rs1_data_s = rs1_data_s;
    end
    if (bus.i_retire && (bus.i_rd_addr == bus.i_rs1_addr) && (cnt_s[bus.i_rs1_addr] == CNT_W'(1))) begin
      rs1_busy_s = 1'b0;
    end else begin
      rs1_busy_s = rs1_busy_s;
    end
`endif
  end

  // source 2 read and busy
  always_comb begin
    rs2_data_s = (bus.i_rs2_addr == '0) ? '0 : regs_q[bus.i_rs2_addr];
    rs2_busy_s = (bus.i_rs2_addr != '0) && (cnt_s[bus.i_rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    if (bus.i_rd_wren && (bus.i_rd_addr == bus.i_rs2_addr) && (bus.i_rs2_addr != '0)) begin
      rs2_data_s = bus.i_rd_data;
    end else begin
      rs2_data_s = rs2_data_s;
    end
    if (bus.i_retire && (bus.i_rd_addr == bus.i_rs2_addr) && (cnt_s[bus.i_rs2_addr] == CNT_W'(1))) begin
      rs2_busy_s = 1'b0;
    end else begin
      rs2_busy_s = rs2_busy_s;
    end
`endif
  end

  assign bus.o_rs1_data    = rs1_data_s;
  assign bus.o_rs2_data    = rs2_data_s;
  assign bus.o_rs1_busy    = rs1_busy_s;
  assign bus.o_rs2_busy    = rs2_busy_s;
  assign bus.o_sb_overflow = ovf_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;
  import rf_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  regfile_sb_if bus ();

  regfile_sb dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    bus.i_rd_wren     = 1'b0;
    bus.i_rd_addr     = '0;
    bus.i_rd_data     = '0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_rd    = '0;
    bus.i_retire      = 1'b0;
    bus.i_flush       = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    idle();
    bus.i_rs1_addr = 5'd5;
    bus.i_rs2_addr = 5'd31;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    settle();
    push(32'h0); chk("rst_rs1_data", bus.o_rs1_data);
    push(32'h0); chk("rst_rs2_data", bus.o_rs2_data);
    push(32'h0); chk("rst_rs1_busy", {31'd0, bus.o_rs1_busy});
    push(32'h0); chk("rst_rs2_busy", {31'd0, bus.o_rs2_busy});
    push(32'h0); chk("rst_ovf", {31'd0, bus.o_sb_overflow});

    // write x5, same-cycle and next-cycle read
    cyc();
    bus.i_rd_wren = 1'b1; bus.i_rd_addr = 5'd5; bus.i_rd_data = 32'hDEADBEEF;
    bus.i_rs1_addr = 5'd5;
    settle();
    push(BYP ? 32'hDEADBEEF : 32'h0); chk("wr_same_cycle", bus.o_rs1_data);
    cyc();
    idle();
    bus.i_rs2_addr = 5'd5;
    settle();
    push(32'hDEADBEEF); chk("wr_next_rs1", bus.o_rs1_data);
    push(32'hDEADBEEF); chk("wr_next_rs2", bus.o_rs2_data);

    // x0 writes discarded, x0 never busy
    bus.i_rd_wren = 1'b1; bus.i_rd_addr = 5'd0; bus.i_rd_data = 32'h12345678;
    bus.i_rs2_addr = 5'd0;
    settle();
    push(32'h0); chk("x0_same_cycle", bus.o_rs2_data);
    cyc();
    idle();
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd0;
    settle();
    push(32'h0); chk("x0_after_wr", bus.o_rs2_data);
    cyc();
    idle();
    settle();
    push(32'h0); chk("x0_busy", {31'd0, bus.o_rs2_busy});

    // rd=7: two issues, retires, simultaneous issue+retire, underflow
    bus.i_rs1_addr = 5'd7;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
    cyc();
    cyc();
    idle();
    settle();
    push(32'h1); chk("x7_busy_cnt2", {31'd0, bus.o_rs1_busy});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd7;
    settle();
    push(32'h1); chk("x7_retire1_same", {31'd0, bus.o_rs1_busy});
    cyc();
    idle();
    settle();
    push(32'h1); chk("x7_busy_cnt1", {31'd0, bus.o_rs1_busy});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd7;
    settle();
    push(BYP ? 32'h0 : 32'h1); chk("x7_retire2_same", {31'd0, bus.o_rs1_busy});
    cyc();
    idle();
    settle();
    push(32'h0); chk("x7_busy_cnt0", {31'd0, bus.o_rs1_busy});
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
    cyc();
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd7;
    cyc();
    idle();
    settle();
    push(32'h1); chk("x7_iss_ret_hold", {31'd0, bus.o_rs1_busy});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd7;
    cyc();
    cyc();
    idle();
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
    cyc();
    idle();
    settle();
    push(32'h1); chk("x7_after_underflow", {31'd0, bus.o_rs1_busy});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd7;
    cyc();
    idle();
    settle();
    push(32'h0); chk("x7_no_wrap", {31'd0, bus.o_rs1_busy});

    // rd=9 saturation and sticky overflow
    bus.i_rs2_addr = 5'd9;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd9;
    cyc();
    cyc();
    cyc();
    settle();
    push(32'h0); chk("ovf_before_sat", {31'd0, bus.o_sb_overflow});
    cyc();
    idle();
    settle();
    push(32'h1); chk("ovf_set", {31'd0, bus.o_sb_overflow});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd9;
    cyc();
    cyc();
    idle();
    settle();
    push(32'h1); chk("x9_cnt1_busy", {31'd0, bus.o_rs2_busy});
    bus.i_retire = 1'b1; bus.i_rd_addr = 5'd9;
    cyc();
    idle();
    settle();
    push(32'h0); chk("x9_cnt0_busy", {31'd0, bus.o_rs2_busy});

    // flush beats issue, concurrent write still lands
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
    cyc();
    cyc();
    bus.i_issue_rd = 5'd4;
    cyc();
    idle();
    bus.i_rs1_addr = 5'd3; bus.i_rs2_addr = 5'd4;
    settle();
    push(32'h1); chk("x3_busy_pre", {31'd0, bus.o_rs1_busy});
    push(32'h1); chk("x4_busy_pre", {31'd0, bus.o_rs2_busy});
    bus.i_flush = 1'b1;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
    bus.i_rd_wren = 1'b1; bus.i_rd_addr = 5'd4; bus.i_rd_data = 32'h000000A5;
    cyc();
    idle();
    settle();
    push(32'h0); chk("flush_x3_busy", {31'd0, bus.o_rs1_busy});
    push(32'h0); chk("flush_x4_busy", {31'd0, bus.o_rs2_busy});
    push(32'h000000A5); chk("flush_x4_data", bus.o_rs2_data);
    push(32'h1); chk("ovf_after_flush", {31'd0, bus.o_sb_overflow});

    // mid-operation reset discards write and issue, clears state
    bus.i_rd_wren = 1'b1; bus.i_rd_addr = 5'd6; bus.i_rd_data = 32'h66666666;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd6;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle();
    bus.i_rs1_addr = 5'd6; bus.i_rs2_addr = 5'd4;
    settle();
    push(32'h0); chk("rst2_x6_data", bus.o_rs1_data);
    push(32'h0); chk("rst2_x6_busy", {31'd0, bus.o_rs1_busy});
    push(32'h0); chk("rst2_x4_data", bus.o_rs2_data);
    push(32'h0); chk("rst2_ovf", {31'd0, bus.o_sb_overflow});

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expectations observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
